// File: rtl/audio_pwm_player.sv
`default_nettype none
// ============================================================================
//  Module   : audio_pwm_player
//  Purpose  : Plays unsigned duty samples from a small FIFO as a PWM stream.
//             Each sample drives REPEAT periods of 2^DATA_W clocks; an empty
//             FIFO at a sample boundary raises a sticky underrun flag.
//  Options  : AUDIO_PWM_HOLD_LAST_EN - on underrun keep the last duty
//             (undefined: fall silent with duty 0).
//  Revision : 1.0 - initial release
// ============================================================================
module audio_pwm_player #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int REPEAT     = 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                act_sonido,
  input  logic [DATA_W-1:0]                   data_in,
  input  logic                                data_valid,
  output logic                                data_ready,
  output logic                                pwm_out,
  output logic                                busy,
  output logic                                underrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fill
);

  localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
  localparam int c_FILL_W = $clog2(FIFO_DEPTH + 1);
  localparam int c_REP_W  = (REPEAT > 1) ? $clog2(REPEAT) : 1;

  localparam logic [DATA_W-1:0]   c_CNT_MAX  = '1;
  localparam logic [c_REP_W-1:0]  c_REP_LAST = c_REP_W'(REPEAT - 1);
  localparam logic [c_FILL_W-1:0] c_FULL     = c_FILL_W'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_PLAY = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_FILL_W-1:0] r_fill;

  logic [DATA_W-1:0]   r_cnt;
  logic [c_REP_W-1:0]  r_rep;
  logic [DATA_W-1:0]   r_duty;
  logic                r_pwm;
  logic                r_underrun;

  logic                w_push;
  logic                w_pop;
  logic                w_load;
  logic                w_starve;
  logic                w_have;
  logic                w_period_end;
  logic                w_rep_last;
  logic [DATA_W-1:0]   w_head;
  logic [DATA_W-1:0]   w_underrun_duty;

  // Pops look only at registered occupancy, so a push in the same cycle
  // into an empty FIFO cannot be consumed until the following edge.
  assign w_have       = (r_fill != '0);
  assign data_ready   = (r_fill != c_FULL);
  assign w_push       = data_valid && data_ready;
  assign w_head       = r_mem[r_rd_ptr];
  assign w_period_end = (r_cnt == c_CNT_MAX);
  assign w_rep_last   = (r_rep == c_REP_LAST);

`ifdef AUDIO_PWM_HOLD_LAST_EN
  assign w_underrun_duty = r_duty;
`else
  assign w_underrun_duty = '0;
`endif

  // Sample storage; contents are only meaningful where fill says so
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // FIFO pointers and occupancy; push and pop together leave fill unchanged
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
    end
  end

  // Player state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state plus pop/load/underrun decisions, taken only at period ends
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_load       = 1'b0;
    w_starve     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (act_sonido && w_have) begin
          w_state_next = S_PLAY;
          w_pop        = 1'b1;
          w_load       = 1'b1;
        end
      end
      S_PLAY: begin
        if (w_period_end) begin
          if (!act_sonido) begin
            w_state_next = S_IDLE;
          end else if (w_rep_last) begin
            if (w_have) begin
              w_pop  = 1'b1;
              w_load = 1'b1;
            end else begin
              w_starve = 1'b1;
            end
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // PWM counter, repeat counter, duty register, output and underrun flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_rep      <= '0;
      r_duty     <= '0;
      r_pwm      <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          r_rep <= '0;
          r_pwm <= 1'b0;
        end
        S_PLAY: begin
          r_cnt <= r_cnt + 1'b1;
          r_pwm <= (r_cnt < r_duty);
          if (w_period_end) begin
            if (!act_sonido || w_rep_last) begin
              r_rep <= '0;
            end else begin
              r_rep <= r_rep + 1'b1;
            end
          end
        end
        default: begin
          r_cnt <= '0;
          r_rep <= '0;
          r_pwm <= 1'b0;
        end
      endcase

      if (w_load) begin
        r_duty <= w_head;
      end else if (w_starve) begin
        r_duty <= w_underrun_duty;
      end

      if (w_starve) begin
        r_underrun <= 1'b1;
      end else if ((r_state == S_IDLE) && w_load) begin
        r_underrun <= 1'b0;
      end
    end
  end

  assign pwm_out  = r_pwm;
  assign busy     = (r_state == S_PLAY);
  assign underrun = r_underrun;
  assign fill     = r_fill;

endmodule
`default_nettype wire

// File: tb/tb_audio_pwm_player.sv
`default_nettype none
// ============================================================================
//  Module   : tb_audio_pwm_player
//  Purpose  : Scoreboard bench for audio_pwm_player. A period-level model
//             predicts the pulse width of every played PWM period; a monitor
//             measures high pulses on pwm_out and compares them in order.
//  Options  : honours AUDIO_PWM_HOLD_LAST_EN like the design.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_audio_pwm_player;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int REP   = 2;
  localparam int PER   = 1 << DW;
`ifdef AUDIO_PWM_HOLD_LAST_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic                           clk;
  logic                           reset;
  logic                           act_sonido;
  logic [DW-1:0]                  data_in;
  logic                           data_valid;
  logic                           data_ready;
  logic                           pwm_out;
  logic                           busy;
  logic                           underrun;
  logic [$clog2(DEPTH+1)-1:0]     fill;

  audio_pwm_player #(
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH),
    .REPEAT     (REP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .act_sonido (act_sonido),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .pwm_out    (pwm_out),
    .busy       (busy),
    .underrun   (underrun),
    .fill       (fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];      // expected pulse widths, in play order
  int mdl_q[$];      // model of FIFO contents
  bit mdl_under = 1'b0;

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic int rand_sample();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return 0;
    if (r == 1) return PER - 1;
    return $urandom_range(1, PER - 2);
  endfunction

  // Monitor: every completed high pulse is one played period with duty > 0
  initial begin
    int hi;
    int e;
    hi = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hi = 0;
      end else if (pwm_out) begin
        hi++;
      end else if (hi > 0) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
        check("pulse_width", hi, e);
        hi = 0;
      end
    end
  end

  // Offer one sample for one clock; accepted only if the FIFO had room
  task automatic push_one(input int v);
    bit room;
    room       = (mdl_q.size() < DEPTH);
    data_valid = 1'b1;
    data_in    = DW'(v);
    @(posedge clk); #1;
    data_valid = 1'b0;
    if (room) mdl_q.push_back(v);
  endtask

  // Play np periods from IDLE, dropping act_sonido 'off' clocks into the
  // last period; optionally offer a sample in the same cycle as act_sonido.
  task automatic play_round(input int np, input int off, input bit conc, input int cval);
    int  duty;
    int  lat;
    int  lat_exp;
    bit  pushes;
    pushes = conc && (mdl_q.size() < DEPTH);
    if (pushes) begin
      data_valid = 1'b1;
      data_in    = DW'(cval);
    end
    act_sonido = 1'b1;
    if (mdl_q.size() == 0 && !pushes) begin
      repeat (20) @(posedge clk);
      #1;
      check("idle_hold_busy", busy, 0);
      check("idle_hold_underrun", underrun, mdl_under);
      act_sonido = 1'b0;
      return;
    end
    if (mdl_q.size() > 0) begin
      duty = mdl_q.pop_front();
      if (pushes) mdl_q.push_back(cval);
      lat_exp = 1;
    end else begin
      mdl_q.push_back(cval);
      duty = mdl_q.pop_front();
      lat_exp = 2;
    end
    mdl_under = 1'b0;
    for (int p = 0; p < np; p++) begin
      if (duty > 0) exp_q.push_back(duty);
      if (p < np - 1 && (p % REP) == REP - 1) begin
        if (mdl_q.size() > 0) begin
          duty = mdl_q.pop_front();
        end else begin
          mdl_under = 1'b1;
          if (!HOLD) duty = 0;
        end
      end
    end
    lat = 0;
    do begin
      @(posedge clk); #1;
      data_valid = 1'b0;
      lat++;
    end while (!busy && lat < 8);
    check("start_latency", lat, lat_exp);
    repeat (PER * (np - 1) + off) @(posedge clk);
    #1;
    act_sonido = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (busy && lat < 2 * PER);
    check("stop_latency", lat, PER - off);
    check("stop_pwm", pwm_out, 0);
    check("stop_fill", fill, mdl_q.size());
    check("stop_ready", data_ready, (mdl_q.size() < DEPTH) ? 1 : 0);
    check("stop_underrun", underrun, mdl_under);
  endtask

  initial begin
    reset      = 1'b1;
    act_sonido = 1'b0;
    data_in    = '0;
    data_valid = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_pwm", pwm_out, 0);
    check("rst_busy", busy, 0);
    check("rst_underrun", underrun, 0);
    check("rst_fill", fill, 0);
    check("rst_ready", data_ready, 1);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_fill", fill, 0);
    check("post_rst_ready", data_ready, 1);

    // Minimum duty, followed by underrun
    push_one(1);
    play_round(4, 128, 1'b0, 0);

    // Fill to capacity, then an extra offer must be ignored
    for (int i = 0; i < DEPTH; i++) push_one(rand_sample());
    check("full_fill", fill, DEPTH);
    check("full_ready", data_ready, 0);
    push_one(rand_sample());
    check("full_fill_after_extra", fill, DEPTH);
    play_round(5, 100, 1'b1, rand_sample());
    if (mdl_q.size() > 0) play_round(REP * mdl_q.size(), 60, 1'b0, 0);

    // Repeat behaviour with two samples
    push_one(64);
    push_one(128);
    play_round(4, 200, 1'b0, 0);

    // Underrun after a sample: hold or silence depending on build
    push_one(200);
    play_round(3, 30, 1'b0, 0);

    // Duty extremes
    push_one(0);
    push_one(PER - 1);
    play_round(4, 5, 1'b0, 0);

    // Enable with empty FIFO, then same-cycle push into empty FIFO
    play_round(2, 10, 1'b0, 0);
    play_round(2, 77, 1'b1, 33);

    // Randomized rounds
    for (int r = 0; r < 10; r++) begin
      int n;
      n = $urandom_range(0, DEPTH - mdl_q.size());
      for (int i = 0; i < n; i++) push_one(rand_sample());
      play_round($urandom_range(1, 4), $urandom_range(1, 250),
                 1'(($urandom_range(0, 1))), rand_sample());
    end

    // Reset mid-play with three samples still buffered
    reset = 1'b1;
    #10;
    reset = 1'b0;
    mdl_q.delete();
    mdl_under = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < DEPTH; i++) push_one(100);
    act_sonido = 1'b1;
    exp_q.push_back(100);
    @(posedge clk); #1;
    check("abort_busy_start", busy, 1);
    repeat (150) @(posedge clk);
    #2;
    check("abort_fill_before", fill, DEPTH - 1);
    reset = 1'b1;
    #1;
    check("abort_pwm", pwm_out, 0);
    check("abort_busy", busy, 0);
    check("abort_fill", fill, 0);
    check("abort_ready", data_ready, 1);
    check("abort_underrun", underrun, 0);
    act_sonido = 1'b0;
    #7;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("pulses_outstanding", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop in case something stalls the stimulus thread
  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/audio_pwm_player.md
AUDIO_PWM_PLAYER -- requirements
Module: audio_pwm_player

Interface
REQ-001 Parameter DATA_W, default 8: sample width and PWM counter width; PWM period is 2^DATA_W clocks.
REQ-002 Parameter FIFO_DEPTH, default 4: sample buffer depth; power of two, minimum 2.
REQ-003 Parameter REPEAT, default 1: PWM periods played per sample; minimum 1.
REQ-004 Clocking: one clock, clk; reset is asynchronous and active-high, named reset.
REQ-005 Port clk, input, 1: system clock, all state on rising edge.
REQ-006 Port reset, input, 1: asynchronous active-high reset.
REQ-007 Port act_sonido, input, 1: play enable.
REQ-008 Port data_in, input, DATA_W: unsigned duty sample.
REQ-009 Port data_valid, input, 1: data_in is offered this cycle.
REQ-010 Port data_ready, output, 1: FIFO can accept a sample; equals not full.
REQ-011 Port pwm_out, output, 1: registered PWM output.
REQ-012 Port busy, output, 1: state is PLAY.
REQ-013 Port underrun, output, 1: sticky flag, FIFO was empty at a sample boundary.
REQ-014 Port fill, output, clog2(FIFO_DEPTH+1): current FIFO occupancy.

Function
REQ-015 Push rule: a push occurs when data_valid and data_ready are both 1; data_valid is ignored while data_ready is 0; the sample is not lost if the source holds it.
REQ-016 Pop visibility: a pop sees only FIFO contents registered before the current edge; a same-cycle push into an empty FIFO is not visible to that pop.
REQ-017 Simultaneous push and pop: both complete and fill is unchanged.
REQ-018 IDLE state: pwm_out=0, counter cnt=0, repeat counter rep=0.
REQ-019 IDLE exit: when act_sonido=1 and fill>0, pop the head into duty, clear underrun, and enter PLAY on the next cycle.
REQ-020 IDLE hold: act_sonido=1 with fill=0 stays in IDLE; underrun is not set.
REQ-021 PLAY counting: cnt increments by 1 each clock and wraps from 2^DATA_W-1 to 0.
REQ-022 PLAY output: pwm_out is registered from (cnt < duty), so it follows cnt by one clock.
REQ-023 Duty extremes: duty=0 gives a constant low; duty=2^DATA_W-1 gives low for exactly 1 clock per period.
REQ-024 Period end: at cnt=2^DATA_W-1, rep increments; when rep=REPEAT-1, a sample boundary occurs and rep returns to 0.
REQ-025 Sample boundary with act_sonido=1: if fill>0, pop into duty; if fill=0, set underrun and load duty per REQ-032.
REQ-026 act_sonido=0 during PLAY: the current PWM period completes and the state returns to IDLE at its final count; no pop occurs and the FIFO is retained.
REQ-027 Samples take effect only at period starts; no mid-period duty change occurs.

Reset
REQ-028 Reset asynchronously drives state to IDLE and sets pwm_out=0, busy=0, underrun=0, cnt=0, rep=0 and duty=0.
REQ-029 Reset empties the FIFO: fill=0 and data_ready=1 from the first edge after release.
REQ-030 Reset asserted mid-PLAY aborts immediately; buffered samples are discarded.

Configuration
REQ-031 Macro AUDIO_PWM_HOLD_LAST_EN selects the underrun duty behaviour.
REQ-032 Macro defined: on underrun, duty keeps the last played sample. Macro undefined: on underrun, duty=0 (silence, pwm_out low).

Verification
REQ-033 Defaults; reset 10 ns; push 8'd1; act_sonido=1 -> busy=1, pwm_out high for 1 clock every 256 clocks; underrun=1 after the first period with the FIFO empty.
REQ-034 Push 4 samples with act_sonido=0 -> fill=4 and data_ready=0; a 5th data_valid is ignored and fill stays 4.
REQ-035 REPEAT=2; samples 8'd64, 8'd128 -> 2 periods of 64 high clocks each, then 2 periods of 128 high clocks each.
REQ-036 Underrun after sample 8'd200 -> with the macro defined, 200 high clocks per period continue; without it, pwm_out stays 0; underrun=1 in both builds.
REQ-037 act_sonido deasserted at cnt=10 -> period runs to cnt=255, then busy=0, pwm_out=0, and fill is unchanged.
REQ-038 Reset pulse mid-PLAY with fill=3 -> pwm_out=0 and fill=0 immediately; underrun=0.
